// File: rtl/pc_fetch.sv
// pc_fetch: program-counter register and single-outstanding instruction-fetch
// sequencer for the RV64I core.
//   clk, rst            : core clock, synchronous active-high reset
//   pcn_i, pc_we_i      : next PC and "current instruction done" strobe
//   imem_req_o/addr_o   : fetch request (registered-state decode only)
//   imem_gnt_i          : request accepted
//   imem_rvalid_i/rdata_i/err_i : response channel
//   pc_o, inst_o, inst_valid_o  : current PC and its instruction for decode
//   fault_o, fault_cause_o, fault_addr_o : sticky fault (01 misaligned, 10 access)
//   fetch_cnt_o         : delivered-instruction count, wraps mod 2^64
module pc_fetch #(
  parameter int unsigned              DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pcn_i,
  input  logic                  pc_we_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  input  logic                  imem_err_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [31:0]           inst_o,
  output logic                  inst_valid_o,
  output logic                  fault_o,
  output logic [1:0]            fault_cause_o,
  output logic [DATA_WIDTH-1:0] fault_addr_o,
  output logic [63:0]           fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]             inst_q, inst_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [1:0]              fault_cause_q, fault_cause_d;
  logic [DATA_WIDTH-1:0]   fault_addr_q, fault_addr_d;
  logic [63:0]             fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_valid_d  = inst_valid_q;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    fetch_cnt_d   = fetch_cnt_q;

    unique case (state_q)
      S_REQ: begin
        if (imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (!imem_err_i) begin
            inst_d       = imem_rdata_i;
            inst_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + 64'd1;
            state_d      = S_HOLD;
          end else begin
            fault_cause_d = 2'b10;
            fault_addr_d  = pc_q;
            state_d       = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (pc_we_i) begin
          inst_valid_d = 1'b0;
          if (pcn_i[1:0] == 2'b00) begin
            pc_d    = pcn_i;
            state_d = S_REQ;
          end else begin
            // Misaligned target: PC keeps the last good value.
            fault_cause_d = 2'b01;
            fault_addr_d  = pcn_i;
            state_d       = S_ERR;
          end
        end
      end
      S_ERR: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      inst_valid_q  <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
      fetch_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_valid_q  <= inst_valid_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign inst_o        = inst_q;
  assign inst_valid_o  = inst_valid_q;
  assign fault_o       = (state_q == S_ERR);
  assign fault_cause_o = fault_cause_q;
  assign fault_addr_o  = fault_addr_q;
  assign fetch_cnt_o   = fetch_cnt_q;

endmodule
